// File: rtl/bang_bang_pfd.sv
// Bang-bang phase/frequency detector for the ADPLL: compares synchronized rising edges of
// the reference and feedback signals and drives the up/down counter instruction.
module bang_bang_pfd #(
    parameter int unsigned ERR_WIDTH   = 8,
    parameter int unsigned LOCK_WINDOW = 2,
    parameter int unsigned LOCK_COUNT  = 16
) (
    input  logic                 fpga_clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 ref_clk_i,
    input  logic                 fb_clk_i,
    output logic [1:0]           count_instr_o,
    output logic [ERR_WIDTH-1:0] err_mag_o,
    output logic                 err_sign_o,
    output logic                 err_valid_o,
    output logic                 slip_o,
    output logic                 lock_o
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [ERR_WIDTH-1:0] MAG_MAX = '1;

    localparam logic [1:0] INSTR_HOLD = 2'b00;
    localparam logic [1:0] INSTR_UP   = 2'b01;
    localparam logic [1:0] INSTR_DOWN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REF_LEAD = 2'd1,
        ST_FB_LEAD  = 2'd2
    } state_e;

    // Input pipelines: [0],[1] synchronize, [2] holds the previous level for edge detect.
    logic [2:0] ref_pipe_q, ref_pipe_d;
    logic [2:0] fb_pipe_q,  fb_pipe_d;
    logic       ref_edge_q, ref_edge_d;
    logic       fb_edge_q,  fb_edge_d;

    state_e                 state_q,       state_d;
    logic [ERR_WIDTH-1:0]   lead_cnt_q,    lead_cnt_d;
    logic [GOOD_W-1:0]      good_cnt_q,    good_cnt_d;
    logic [1:0]             count_instr_q, count_instr_d;
    logic [ERR_WIDTH-1:0]   err_mag_q,     err_mag_d;
    logic                   err_sign_q,    err_sign_d;
    logic                   err_valid_q,   err_valid_d;
    logic                   slip_q,        slip_d;
    logic                   lock_q,        lock_d;

    logic                   done;
    logic [ERR_WIDTH-1:0]   done_mag;
    logic                   done_sign;
    logic [ERR_WIDTH-1:0]   lead_inc;

    // Edge pulses are registered so both paths see identical latency.
    always_comb begin
        ref_pipe_d = {ref_pipe_q[1:0], ref_clk_i};
        fb_pipe_d  = {fb_pipe_q[1:0],  fb_clk_i};
        ref_edge_d = ref_pipe_q[1] & ~ref_pipe_q[2];
        fb_edge_d  = fb_pipe_q[1]  & ~fb_pipe_q[2];
    end

    always_comb begin
        lead_inc = (lead_cnt_q == MAG_MAX) ? lead_cnt_q : lead_cnt_q + ERR_WIDTH'(1);
    end

    // Detector state machine, comparison bookkeeping and lock tracking.
    always_comb begin
        state_d     = state_q;
        lead_cnt_d  = lead_cnt_q;
        good_cnt_d  = good_cnt_q;
        err_mag_d   = err_mag_q;
        err_sign_d  = err_sign_q;
        err_valid_d = 1'b0;
        slip_d      = 1'b0;
        done        = 1'b0;
        done_mag    = '0;
        done_sign   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ref_edge_q && fb_edge_q) begin
                    done = 1'b1;
                end else if (ref_edge_q) begin
                    state_d    = ST_REF_LEAD;
                    lead_cnt_d = ERR_WIDTH'(1);
                end else if (fb_edge_q) begin
                    state_d    = ST_FB_LEAD;
                    lead_cnt_d = ERR_WIDTH'(1);
                end
            end
            ST_REF_LEAD: begin
                if (fb_edge_q) begin
                    state_d  = ST_IDLE;
                    done     = 1'b1;
                    done_mag = lead_cnt_q;
                end else begin
                    lead_cnt_d = lead_inc;
                    slip_d     = ref_edge_q;
                end
            end
            ST_FB_LEAD: begin
                if (ref_edge_q) begin
                    state_d   = ST_IDLE;
                    done      = 1'b1;
                    done_mag  = lead_cnt_q;
                    done_sign = 1'b1;
                end else begin
                    lead_cnt_d = lead_inc;
                    slip_d     = fb_edge_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (done) begin
            err_mag_d   = done_mag;
            err_sign_d  = done_sign;
            err_valid_d = 1'b1;
            if (32'(done_mag) <= LOCK_WINDOW) begin
                if (good_cnt_q != GOOD_W'(LOCK_COUNT)) begin
                    good_cnt_d = good_cnt_q + GOOD_W'(1);
                end
            end else begin
                good_cnt_d = '0;
            end
        end

        if (slip_d) begin
            good_cnt_d = '0;
        end

        // Soft clear wipes detector state but leaves the input pipelines alone.
        if (clear_i) begin
            state_d     = ST_IDLE;
            lead_cnt_d  = '0;
            good_cnt_d  = '0;
            err_mag_d   = '0;
            err_sign_d  = 1'b0;
            err_valid_d = 1'b0;
            slip_d      = 1'b0;
        end

        lock_d = (good_cnt_d == GOOD_W'(LOCK_COUNT)) && !clear_i;

        case (state_d)
            ST_REF_LEAD: count_instr_d = INSTR_UP;
            ST_FB_LEAD:  count_instr_d = INSTR_DOWN;
            default:     count_instr_d = INSTR_HOLD;
        endcase
    end

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            ref_pipe_q    <= '0;
            fb_pipe_q     <= '0;
            ref_edge_q    <= 1'b0;
            fb_edge_q     <= 1'b0;
            state_q       <= ST_IDLE;
            lead_cnt_q    <= '0;
            good_cnt_q    <= '0;
            count_instr_q <= INSTR_HOLD;
            err_mag_q     <= '0;
            err_sign_q    <= 1'b0;
            err_valid_q   <= 1'b0;
            slip_q        <= 1'b0;
            lock_q        <= 1'b0;
        end else begin
            ref_pipe_q    <= ref_pipe_d;
            fb_pipe_q     <= fb_pipe_d;
            ref_edge_q    <= ref_edge_d;
            fb_edge_q     <= fb_edge_d;
            state_q       <= state_d;
            lead_cnt_q    <= lead_cnt_d;
            good_cnt_q    <= good_cnt_d;
            count_instr_q <= count_instr_d;
            err_mag_q     <= err_mag_d;
            err_sign_q    <= err_sign_d;
            err_valid_q   <= err_valid_d;
            slip_q        <= slip_d;
            lock_q        <= lock_d;
        end
    end

    assign count_instr_o = count_instr_q;
    assign err_mag_o     = err_mag_q;
    assign err_sign_o    = err_sign_q;
    assign err_valid_o   = err_valid_q;
    assign slip_o        = slip_q;
    assign lock_o        = lock_q;

endmodule

// File: tb/tb_bang_bang_pfd.sv
// Bench for bang_bang_pfd: directed waveform scenarios plus randomized segments, every
// cycle compared against a behavioural model of the detector.
module tb_bang_bang_pfd;

    localparam int LC  = 4;
    localparam int LW  = 2;
    localparam int SAT = 255;

    logic       clk = 1'b0;
    logic       reset_i, clear_i, ref_clk_i, fb_clk_i;
    logic [1:0] count_instr_o;
    logic [7:0] err_mag_o;
    logic       err_sign_o, err_valid_o, slip_o, lock_o;

    always #5 clk = ~clk;

    bang_bang_pfd #(.ERR_WIDTH(8), .LOCK_WINDOW(LW), .LOCK_COUNT(LC)) dut (
        .fpga_clk_i    (clk),
        .reset_i       (reset_i),
        .clear_i       (clear_i),
        .ref_clk_i     (ref_clk_i),
        .fb_clk_i      (fb_clk_i),
        .count_instr_o (count_instr_o),
        .err_mag_o     (err_mag_o),
        .err_sign_o    (err_sign_o),
        .err_valid_o   (err_valid_o),
        .slip_o        (slip_o),
        .lock_o        (lock_o)
    );

    int checks = 0;
    int errors = 0;

    // Model: leader 0 none, 1 ref, 2 fb; lead duration = cycles since leader was set.
    int         m_leader = 0, m_start = 0, m_good = 0, m_cyc = 0, nr = 0;
    logic       rs [1:4];
    logic       fs [1:4];
    logic [1:0] e_instr = 2'b00;
    int         e_mag = 0;
    logic       e_sign = 1'b0, e_valid = 1'b0, e_slip = 1'b0, e_lock = 1'b0;

    // Observation statistics for directed scenario checks.
    int   n_valid, n_slip, n_active, last_mag, last_sign, cur_run, last_run, valid_at_lock;
    logic lock_seen;
    logic [1:0] instr_at_clr;
    logic valid_at_clr, lock_at_clr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_valid = 0; n_slip = 0; n_active = 0; last_mag = -1; last_sign = -1;
        cur_run = 0; last_run = 0; valid_at_lock = -1; lock_seen = 1'b0;
    endtask

    task automatic complete(input int d, input logic s);
        e_valid = 1'b1;
        e_mag   = d;
        e_sign  = s;
        if (d <= LW) m_good = (m_good + 1 > LC) ? LC : m_good + 1;
        else         m_good = 0;
    endtask

    task automatic model_edge(input logic r, input logic f, input logic rst, input logic clr);
        logic r_ev, f_ev;
        int   dur;
        // A level first captured at edge M-3 after a low at M-4 acts at edge M.
        r_ev = rs[3] && !rs[4] && (nr >= 2);
        f_ev = fs[3] && !fs[4] && (nr >= 2);
        for (int k = 4; k > 1; k--) begin
            rs[k] = rs[k-1];
            fs[k] = fs[k-1];
        end
        rs[1] = rst ? 1'b0 : r;
        fs[1] = rst ? 1'b0 : f;
        nr    = rst ? 0 : nr + 1;
        m_cyc++;
        dur = (m_cyc - m_start > SAT) ? SAT : m_cyc - m_start;
        if (rst || clr) begin
            m_leader = 0; m_good = 0;
            e_instr = 2'b00; e_mag = 0; e_sign = 1'b0;
            e_valid = 1'b0; e_slip = 1'b0; e_lock = 1'b0;
        end else begin
            e_valid = 1'b0;
            e_slip  = 1'b0;
            if (m_leader == 0) begin
                if (r_ev && f_ev) complete(0, 1'b0);
                else if (r_ev) begin m_leader = 1; m_start = m_cyc; end
                else if (f_ev) begin m_leader = 2; m_start = m_cyc; end
            end else if ((m_leader == 1 && f_ev) || (m_leader == 2 && r_ev)) begin
                complete(dur, m_leader == 2);
                m_leader = 0;
            end else if ((m_leader == 1 && r_ev) || (m_leader == 2 && f_ev)) begin
                e_slip = 1'b1;
                m_good = 0;
            end
            e_lock  = (m_good == LC);
            e_instr = (m_leader == 1) ? 2'b01 : (m_leader == 2) ? 2'b10 : 2'b00;
        end
    endtask

    task automatic step(input logic r, input logic f, input logic rst, input logic clr);
        ref_clk_i = r;
        fb_clk_i  = f;
        reset_i   = rst;
        clear_i   = clr;
        @(posedge clk);
        model_edge(r, f, rst, clr);
        #1;
        chk("count_instr", 32'(count_instr_o), 32'(e_instr));
        chk("err_mag",     32'(err_mag_o),     32'(e_mag));
        chk("err_sign",    32'(err_sign_o),    32'(e_sign));
        chk("err_valid",   32'(err_valid_o),   32'(e_valid));
        chk("slip",        32'(slip_o),        32'(e_slip));
        chk("lock",        32'(lock_o),        32'(e_lock));
        if (err_valid_o === 1'b1) begin
            n_valid++;
            last_mag  = int'(err_mag_o);
            last_sign = int'(err_sign_o);
        end
        if (slip_o === 1'b1) n_slip++;
        if (lock_o === 1'b1 && !lock_seen) begin
            valid_at_lock = n_valid;
            lock_seen     = 1'b1;
        end
        if (count_instr_o === 2'b00) begin
            if (cur_run > 0) last_run = cur_run;
            cur_run = 0;
        end else begin
            cur_run++;
            n_active++;
        end
        if (clr) begin
            instr_at_clr = count_instr_o;
            valid_at_clr = err_valid_o;
            lock_at_clr  = lock_o;
        end
    endtask

    // Square waves: period p (0 = held low), delayed d cycles, high for the first half.
    task automatic run(input int n, input int rp, input int fp, input int ro, input int fo,
                       input int clr_at);
        for (int i = 0; i < n; i++) begin
            logic r, f;
            r = 1'b0;
            f = 1'b0;
            if (rp > 0) r = ((i + 100 * rp - ro) % rp) < rp / 2;
            if (fp > 0) f = ((i + 100 * fp - fo) % fp) < fp / 2;
            step(r, f, 1'b0, i == clr_at);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [1:0] lat [0:3];
        for (int k = 1; k <= 4; k++) begin
            rs[k] = 1'b0;
            fs[k] = 1'b0;
        end
        clear_stats();

        // Reset with toggling inputs, then edge-to-response latency.
        for (int i = 0; i < 4; i++) step(i % 2 == 0, i % 2 == 1, 1'b1, 1'b0);
        chk("rst_instr", 32'(count_instr_o), 32'(0));
        chk("rst_lock",  32'(lock_o),        32'(0));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            lat[i] = count_instr_o;
        end
        chk("latency_n2", 32'(lat[2]), 32'(0));
        chk("latency_n3", 32'(lat[3]), 32'(1));

        // Ref leads by 5 cycles.
        do_reset(2);
        clear_stats();
        run(160, 40, 40, 0, 5, -1);
        chk("ref_lead_mag",   32'(last_mag),  32'(5));
        chk("ref_lead_sign",  32'(last_sign), 32'(0));
        chk("ref_lead_nval",  32'(n_valid),   32'(4));
        chk("ref_lead_run",   32'(last_run),  32'(5));

        // Fb leads by 7 cycles.
        do_reset(2);
        clear_stats();
        run(160, 40, 40, 7, 0, -1);
        chk("fb_lead_mag",  32'(last_mag),  32'(7));
        chk("fb_lead_sign", 32'(last_sign), 32'(1));
        chk("fb_lead_run",  32'(last_run),  32'(7));

        // Coincident edges acquire lock, then a 3-cycle offset drops it.
        do_reset(2);
        clear_stats();
        run(200, 40, 40, 0, 0, -1);
        chk("coinc_active",    32'(n_active),      32'(0));
        chk("coinc_mag",       32'(last_mag),      32'(0));
        chk("coinc_lock_at",   32'(valid_at_lock), 32'(LC));
        chk("coinc_lock",      32'(lock_o),        32'(1));
        clear_stats();
        run(80, 40, 40, 0, 3, -1);
        chk("offset_mag",  32'(last_mag), 32'(3));
        chk("offset_lock", 32'(lock_o),   32'(0));

        // Fb stopped: slips on every later ref edge, counter saturates.
        do_reset(2);
        clear_stats();
        run(320, 20, 0, 0, 0, -1);
        chk("slip_count", 32'(n_slip),         32'(15));
        chk("slip_instr", 32'(count_instr_o),  32'(1));
        chk("slip_lock",  32'(lock_o),         32'(0));
        run(10, 0, 40, 0, 0, -1);
        chk("sat_mag",  32'(last_mag),  32'(SAT));
        chk("sat_sign", 32'(last_sign), 32'(0));

        // Soft clear in the middle of a ref lead.
        do_reset(2);
        clear_stats();
        run(50, 40, 40, 0, 15, 10);
        chk("clr_instr", 32'(instr_at_clr), 32'(0));
        chk("clr_valid", 32'(valid_at_clr), 32'(0));
        chk("clr_lock",  32'(lock_at_clr),  32'(0));
        chk("clr_nval",  32'(n_valid),      32'(1));
        chk("clr_mag",   32'(last_mag),     32'(25));
        chk("clr_sign",  32'(last_sign),    32'(1));

        // Randomized segments with occasional soft clears.
        do_reset(2);
        for (int s = 0; s < 10; s++) begin
            int rp, fp, ro, fo;
            rp = int'($urandom_range(8, 48));
            fp = ($urandom_range(0, 1) == 1) ? rp : int'($urandom_range(8, 60));
            ro = int'($urandom_range(0, 7));
            fo = int'($urandom_range(0, 12));
            run(150, rp, fp, ro, fo, int'($urandom_range(0, 300)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
